// File: rtl/noc_params_pkg.sv
// Shared NoC router types and flit field helpers.
// Flit layout: [W-1:W-2] type, followed by the destination field, then payload.
package noc_params_pkg;

  localparam int FLIT_TYPE_W = 2;
  localparam int MAX_FLIT_W  = 64;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_type_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    VA     = 2'b01,
    ACTIVE = 2'b10
  } fsm_state_t;

  // Callers zero-extend their flit to MAX_FLIT_W and pass the real width.
  function automatic flit_type_t type_of(input logic [MAX_FLIT_W-1:0] flit,
                                         input int flit_w);
    logic [MAX_FLIT_W-1:0] sh;
    sh = flit >> (flit_w - FLIT_TYPE_W);
    return flit_type_t'(sh[FLIT_TYPE_W-1:0]);
  endfunction

  function automatic logic [MAX_FLIT_W-1:0] dest_of(input logic [MAX_FLIT_W-1:0] flit,
                                                    input int flit_w,
                                                    input int dest_w);
    logic [MAX_FLIT_W-1:0] sh;
    logic [MAX_FLIT_W-1:0] mask;
    sh   = flit >> (flit_w - FLIT_TYPE_W - dest_w);
    mask = {MAX_FLIT_W{1'b1}} >> (MAX_FLIT_W - dest_w);
    return sh & mask;
  endfunction

endpackage

// File: rtl/vc_input_ctrl_buffer.sv
// circular_buffer: FIFO of flits with combinational front-of-queue output.
// A write into a full buffer is accepted only when a read happens in the same cycle.
module circular_buffer #(
  parameter int BUFFER_SIZE = 8,
  parameter int FLIT_SIZE   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read_i,
  input  logic                 write_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 is_full_o,
  output logic                 is_empty_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_SIZE);

  logic [FLIT_SIZE-1:0] mem_q [BUFFER_SIZE];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 do_rd, do_wr;

  assign is_empty_o = (count_q == '0);
  assign is_full_o  = (count_q == FULL_CNT);
  assign do_rd      = read_i && !is_empty_o;
  assign do_wr      = write_i && (!is_full_o || do_rd);
  assign data_o     = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
    count_d  = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_rd && !do_wr) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/vc_input_ctrl.sv
// Per-VC input controller: buffers incoming flits, requests VC allocation for
// head flits, drains on switch grants and returns one credit per popped flit.
module vc_input_ctrl
  import noc_params_pkg::*;
#(
  parameter int BUFFER_SIZE = 8,
  parameter int FLIT_SIZE   = 16,
  parameter int DEST_SIZE   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 valid_i,
  output logic                 va_request_o,
  output logic [DEST_SIZE-1:0] va_dest_o,
  input  logic                 va_grant_i,
  output logic [FLIT_SIZE-1:0] flit_o,
  output logic                 flit_valid_o,
  input  logic                 sa_grant_i,
  output logic                 credit_o,
  output logic                 overflow_o,
  output logic                 protocol_err_o,
  output logic                 is_empty_o,
  output logic                 is_full_o
);

  fsm_state_t           state_q, state_d;
  logic                 overflow_q, overflow_d;
  logic                 perr_q, perr_d;
  logic [FLIT_SIZE-1:0] front;
  logic                 buf_empty, buf_full;
  logic                 pop, wr, idle_drop, front_is_head;
  flit_type_t           front_type;
  logic [DEST_SIZE-1:0] front_dest;

  circular_buffer #(
    .BUFFER_SIZE(BUFFER_SIZE),
    .FLIT_SIZE  (FLIT_SIZE)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .read_i    (pop),
    .write_i   (wr),
    .data_i    (data_i),
    .data_o    (front),
    .is_full_o (buf_full),
    .is_empty_o(buf_empty)
  );

  always_comb begin
    front_type    = type_of(MAX_FLIT_W'(front), FLIT_SIZE);
    front_dest    = DEST_SIZE'(dest_of(MAX_FLIT_W'(front), FLIT_SIZE, DEST_SIZE));
    front_is_head = (front_type == HEAD) || (front_type == HEADTAIL);
    flit_valid_o  = (state_q == ACTIVE) && !buf_empty;
    idle_drop     = (state_q == IDLE) && !buf_empty && !front_is_head;
    // Pops are held off during reset so no credit escapes for discarded flits.
    pop           = rst && (idle_drop || (flit_valid_o && sa_grant_i));
    wr            = valid_i && (!buf_full || pop);
    overflow_d    = overflow_q || (valid_i && buf_full && !pop);
    perr_d        = perr_q || idle_drop;

    state_d = state_q;
    case (state_q)
      IDLE:   if (!buf_empty && front_is_head) state_d = VA;
      VA:     if (va_grant_i) state_d = ACTIVE;
      ACTIVE: if (pop && ((front_type == TAIL) || (front_type == HEADTAIL))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      perr_q     <= perr_d;
    end
  end

  assign va_request_o   = (state_q == VA);
  assign va_dest_o      = va_request_o ? front_dest : '0;
  assign flit_o         = buf_empty ? '0 : front;
  assign credit_o       = pop;
  assign overflow_o     = overflow_q;
  assign protocol_err_o = perr_q;
  assign is_empty_o     = buf_empty;
  assign is_full_o      = buf_full;

endmodule

// File: doc/vc_input_ctrl.md
Name: vc_input_ctrl

Overview:
- Per-virtual-channel input controller for a router input port.
- Owns one circular_buffer instance and sequences it: writes arriving flits, classifies the flit at the front of the buffer, requests VC allocation for head flits, drains flits on switch-allocation grants and returns one credit per drained flit.
- Sits between the link receiver and the VC/switch allocators.

Parameters:
- BUFFER_SIZE, 8, flit slots in the buffer; power of two, at least 2.
- FLIT_SIZE, 16, flit width in bits.
- DEST_SIZE, 4, destination field width in bits; DEST_SIZE+2 <= FLIT_SIZE.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- data_i  in  FLIT_SIZE  incoming flit.
- valid_i  in  1  data_i carries a flit this cycle.
- va_request_o  out  1  VC allocation request, held while in state VA.
- va_dest_o  out  DEST_SIZE  destination field of the front head flit; valid while va_request_o=1.
- va_grant_i  in  1  VC allocation granted.
- flit_o  out  FLIT_SIZE  front flit of the buffer.
- flit_valid_o  out  1  state ACTIVE and buffer non-empty.
- sa_grant_i  in  1  switch grant; pops the front flit when flit_valid_o=1.
- credit_o  out  1  one-cycle pulse per popped flit.
- overflow_o  out  1  sticky: a flit arrived while the buffer was full and nothing was popped.
- protocol_err_o  out  1  sticky: a non-head flit reached the front in state IDLE.
- is_empty_o  out  1  buffer empty.
- is_full_o  out  1  buffer full.

Behaviour:
- Flit format:
  - [FLIT_SIZE-1:FLIT_SIZE-2] is the type: HEAD=00, BODY=01, TAIL=10, HEADTAIL=11.
  - [FLIT_SIZE-3:FLIT_SIZE-2-DEST_SIZE] is dest, meaningful in head flits only.
- Reset (rst=0 at a clock edge):
  - buffer emptied, pointers zero, state IDLE.
  - All outputs 0, except is_empty_o=1.
  - Reset mid-packet discards all stored flits and returns no credits for them.
- Write: when valid_i=1, the flit is written if the buffer is not full, or if it is full and a pop occurs the same cycle (simultaneous read/write). Otherwise the flit is discarded and overflow_o is set.
- Buffer output: the buffer presents its front flit combinationally; flit_o equals the front flit. A flit written at edge N is visible at the front from cycle N+1 at the earliest.
- FSM state IDLE:
  - Buffer empty: stay IDLE.
  - Front type HEAD or HEADTAIL: go to VA next cycle.
  - Front type BODY or TAIL: pop it silently (credit_o pulses), set protocol_err_o, stay IDLE.
- FSM state VA:
  - va_request_o=1 and va_dest_o=dest of the front flit.
  - va_grant_i=1: go to ACTIVE next cycle.
  - va_grant_i is ignored in any other state.
- FSM state ACTIVE:
  - flit_valid_o = !is_empty_o.
  - sa_grant_i=1 with flit_valid_o=1 pops the front flit; credit_o=1 in the same cycle as the pop.
  - Popped flit type TAIL or HEADTAIL: go to IDLE next cycle.
  - Empty buffer mid-packet: stay ACTIVE and wait.
  - sa_grant_i with flit_valid_o=0 is ignored.
- Latency, empty buffer to head on flit_o:
  - head written at edge N, va_request_o high in cycle N+2.
  - grant at cycle N+2, flit_valid_o in cycle N+3.
- Back-to-back packets: the next packet's head waits through IDLE then VA. There is no direct ACTIVE-to-VA transition.
- Sticky flags clear only on reset.
- Pointers wrap modulo BUFFER_SIZE. The occupancy counter spans 0..BUFFER_SIZE: full when count=BUFFER_SIZE, empty when count=0.

Decomposition:
- Shared package noc_params_pkg holds:
  - flit_type_t enum (HEAD, BODY, TAIL, HEADTAIL);
  - fsm_state_t enum (IDLE, VA, ACTIVE);
  - FLIT_TYPE_W=2 constant;
  - field-extract helper functions for type and dest.
- One sub-module, circular_buffer (BUFFER_SIZE, FLIT_SIZE): ports read_i, write_i, data_i, data_o, is_full_o, is_empty_o.
- The FSM, write gating, credit logic and error flags live in vc_input_ctrl.

Test Plan:
- Reset, then write HEAD dest=4'h5 + BODY + TAIL; grant VA at the first va_request_o, hold sa_grant_i=1 -> va_dest_o=5; flits leave in order; exactly 3 credit_o pulses; state IDLE afterwards.
- Write 9 flits without popping (BUFFER_SIZE=8) -> is_full_o=1 after the 8th; overflow_o=1 after the 9th; the 9th flit is never output.
- Full buffer in ACTIVE with valid_i=1 and sa_grant_i=1 for 2 cycles -> no overflow; is_full_o stays 1; 2 credits; flit order preserved across pointer wrap.
- BODY written as the first flit after reset -> popped with one credit; protocol_err_o=1; va_request_o never asserted.
- HEADTAIL dest=4'hA followed by HEAD dest=4'h3 -> first packet completes in 1 pop; va_request_o reasserts with va_dest_o=3.
- rst=0 in ACTIVE with 4 flits buffered -> next cycle is_empty_o=1, flit_valid_o=0, credit_o=0, both error flags 0.
